// File: rtl/mips_arb_pkg.sv
// Shared types and constants for the Harvard-CPU memory arbiter.
package mips_arb_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;

  localparam logic [BE_W-1:0] BYTEEN_ALL = 4'hF;

  typedef enum logic [2:0] {
    FETCH,
    DECIDE,
    DREAD,
    DWRITE,
    STEP,
    HALT
  } arb_state_t;

  // Bus addresses are always word aligned; byte lanes are handled by the core's merge.
  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/mips_mem_arbiter_if.sv
// Single-ported wait-stated memory bus shared by the CPU's instruction and data ports.
interface mips_mem_arbiter_if;
  import mips_arb_pkg::*;

  logic [ADDR_W-1:0] mem_address;
  logic              mem_read;
  logic              mem_write;
  logic [DATA_W-1:0] mem_writedata;
  logic [BE_W-1:0]   mem_byteenable;
  logic              mem_waitrequest;
  logic [DATA_W-1:0] mem_readdata;

  modport master (
    output mem_address, mem_read, mem_write, mem_writedata, mem_byteenable,
    input  mem_waitrequest, mem_readdata
  );

  modport slave (
    input  mem_address, mem_read, mem_write, mem_writedata, mem_byteenable,
    output mem_waitrequest, mem_readdata
  );

endinterface

// File: rtl/mips_arb_watchdog.sv
// Counts consecutive stalled cycles of an outstanding bus access; flags the last allowed one.
module mips_arb_watchdog #(
  parameter int unsigned WAIT_LIMIT = 256
) (
  input  logic clk,
  input  logic reset,
  input  logic busy,
  input  logic accept,
  output logic timeout
);

  localparam int unsigned CW = $clog2(WAIT_LIMIT + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!busy || accept) begin
      cnt_d = '0;
    end else if (cnt_q != CW'(WAIT_LIMIT)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Fires in the WAIT_LIMIT-th stalled cycle so the strobe is gone in the next one.
  assign timeout = busy && !accept && (cnt_q == CW'(WAIT_LIMIT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mips_mem_arbiter.sv
// Sequences fetch / data read / data write for each CPU step over one bus and
// releases exactly one enabled CPU clock edge per completed step.
module mips_mem_arbiter
  import mips_arb_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = 256,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cpu_reset,
  input  logic                cpu_active,
  input  logic [ADDR_W-1:0]   instr_address,
  input  logic [ADDR_W-1:0]   data_address,
  input  logic                data_read,
  input  logic                data_write,
  input  logic [DATA_W-1:0]   data_writedata,
  output logic                cpu_clk_enable,
  output logic [DATA_W-1:0]   instr_readdata,
  output logic [DATA_W-1:0]   data_readdata,
  mips_mem_arbiter_if.master  mem,
  output logic                halted,
  output logic                bus_error,
  output logic [CNT_W-1:0]    step_count
);

  arb_state_t        state_q, state_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic              clken_q, clken_d;
  logic [DATA_W-1:0] ird_q, ird_d;
  logic [DATA_W-1:0] drd_q, drd_d;
  logic [CNT_W-1:0]  steps_q, steps_d;
  logic              halted_q, halted_d;
  logic              err_q, err_d;

  logic rd_c, wr_c, busy_c, accept_c, timeout_c;

  // cpu_reset silences the bus in the very cycle it is raised.
  assign rd_c     = rd_q && !cpu_reset;
  assign wr_c     = wr_q && !cpu_reset;
  assign busy_c   = rd_c || wr_c;
  assign accept_c = busy_c && !mem.mem_waitrequest;

  mips_arb_watchdog #(
    .WAIT_LIMIT (WAIT_LIMIT)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .busy    (busy_c),
    .accept  (accept_c),
    .timeout (timeout_c)
  );

  always_comb begin
    state_d  = state_q;
    ird_d    = ird_q;
    drd_d    = drd_q;
    steps_d  = steps_q;
    halted_d = halted_q;
    err_d    = err_q;

    case (state_q)
      FETCH: begin
        if (accept_c) begin
          ird_d   = mem.mem_readdata;
          state_d = DECIDE;
        end
      end
      DECIDE: begin
        if (data_read)       state_d = DREAD;
        else if (data_write) state_d = DWRITE;
        else                 state_d = STEP;
      end
      DREAD: begin
        if (accept_c) begin
          drd_d   = mem.mem_readdata;
          state_d = data_write ? DWRITE : STEP;
        end
      end
      DWRITE: begin
        if (accept_c) state_d = STEP;
      end
      STEP:    state_d = cpu_active ? FETCH : HALT;
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase

    if (timeout_c) begin
      state_d = HALT;
      err_d   = 1'b1;
    end

    if (state_d == STEP && !(&steps_q)) steps_d = steps_q + CNT_W'(1);
    if (state_d == HALT)                halted_d = 1'b1;

    if (cpu_reset) begin
      state_d  = FETCH;
      err_d    = 1'b0;
      halted_d = 1'b0;
      steps_d  = '0;
    end

    // Strobes and the enable pulse are registered versions of the upcoming state.
    rd_d    = (state_d == FETCH || state_d == DREAD) && !cpu_reset;
    wr_d    = (state_d == DWRITE) && !cpu_reset;
    clken_d = (state_d == STEP) && !cpu_reset;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= FETCH;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      clken_q  <= 1'b0;
      ird_q    <= '0;
      drd_q    <= '0;
      steps_q  <= '0;
      halted_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      clken_q  <= clken_d;
      ird_q    <= ird_d;
      drd_q    <= drd_d;
      steps_q  <= steps_d;
      halted_q <= halted_d;
      err_q    <= err_d;
    end
  end

  // Address/data follow the live strobe so they are zero whenever the bus is idle.
  always_comb begin
    mem.mem_read       = rd_c;
    mem.mem_write      = wr_c;
    mem.mem_address    = '0;
    mem.mem_writedata  = '0;
    mem.mem_byteenable = '0;
    if (rd_c) begin
      mem.mem_address = word_align((state_q == FETCH) ? instr_address : data_address);
    end else if (wr_c) begin
      mem.mem_address    = word_align(data_address);
      mem.mem_writedata  = data_writedata;
      mem.mem_byteenable = BYTEEN_ALL;
    end
  end

  assign cpu_clk_enable = clken_q || (cpu_reset && reset);
  assign instr_readdata = ird_q;
  assign data_readdata  = drd_q;
  assign halted         = halted_q;
  assign bus_error      = err_q;
  assign step_count     = steps_q;

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Directed bench: per-cycle expected bus/CPU trace built from the step latency rules.
module tb_mips_mem_arbiter;

  localparam int unsigned WL   = 4;
  localparam int unsigned CW   = 2;
  localparam logic [31:0] GARB = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b0;
  logic        cpu_reset = 1'b0;
  logic        cpu_active = 1'b0;
  logic [31:0] instr_address = '0;
  logic [31:0] data_address = '0;
  logic        data_read = 1'b0;
  logic        data_write = 1'b0;
  logic [31:0] data_writedata = '0;
  logic        cpu_clk_enable;
  logic [31:0] instr_readdata;
  logic [31:0] data_readdata;
  logic        halted;
  logic        bus_error;
  logic [CW-1:0] step_count;

  mips_mem_arbiter_if bus ();

  mips_mem_arbiter #(
    .WAIT_LIMIT (WL),
    .CNT_W      (CW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .cpu_reset      (cpu_reset),
    .cpu_active     (cpu_active),
    .instr_address  (instr_address),
    .data_address   (data_address),
    .data_read      (data_read),
    .data_write     (data_write),
    .data_writedata (data_writedata),
    .cpu_clk_enable (cpu_clk_enable),
    .instr_readdata (instr_readdata),
    .data_readdata  (data_readdata),
    .mem            (bus),
    .halted         (halted),
    .bus_error      (bus_error),
    .step_count     (step_count)
  );

  typedef struct {
    logic        rst_n, cpurst, dr, dw, act, waitr;
    logic [31:0] ia, da, wd, rdata;
    logic        rd, wr, clken, halted, err;
    logic [31:0] addr, wdo, ird, drd, steps;
  } cyc_t;

  cyc_t q[$];

  // Stimulus currently presented and expected architectural state.
  logic        s_rst = 1'b0, s_cpurst = 1'b0, s_dr = 1'b0, s_dw = 1'b0, s_act = 1'b1;
  logic [31:0] s_ia = '0, s_da = '0, s_wd = '0;
  logic [31:0] e_ird = '0, e_drd = '0, e_steps = '0;
  logic        e_halt = 1'b0, e_err = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lat_first, lat_en, n_en, n_bus;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%h expected=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic push(input logic rd, input logic wr, input logic clken, input logic waitr,
                      input logic [31:0] addr, input logic [31:0] rdata);
    cyc_t r;
    r.rst_n = s_rst;  r.cpurst = s_cpurst; r.dr = s_dr; r.dw = s_dw; r.act = s_act;
    r.ia = s_ia; r.da = s_da; r.wd = s_wd;
    r.waitr = waitr; r.rdata = rdata;
    r.rd = rd; r.wr = wr; r.clken = clken;
    r.addr = (rd || wr) ? (addr & 32'hFFFF_FFFC) : 32'h0;
    r.wdo  = wr ? s_wd : 32'h0;
    r.ird = e_ird; r.drd = e_drd; r.steps = e_steps; r.halted = e_halt; r.err = e_err;
    q.push_back(r);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) push(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, GARB);
  endtask

  task automatic access(input logic is_wr, input logic [31:0] a, input int waits,
                        input logic [31:0] rdata);
    for (int i = 0; i < waits; i++) push(!is_wr, is_wr, 1'b0, 1'b1, a, GARB);
    push(!is_wr, is_wr, 1'b0, 1'b0, a, rdata);
  endtask

  // One complete CPU step: fetch, decide, optional read, optional write, enable pulse.
  task automatic gen_step(input logic [31:0] ia, input logic [31:0] iw, input logic [31:0] da,
                          input logic dr, input logic dw, input logic act,
                          input logic [31:0] rw, input logic [31:0] wd_pre,
                          input logic [31:0] wd_post, input int wf, input int wr_w, input int ww);
    s_ia = ia; s_da = da; s_dr = dr; s_dw = dw; s_act = act; s_wd = wd_pre;
    access(1'b0, ia, wf, iw);
    e_ird = iw;
    idle(1);
    if (dr) begin
      access(1'b0, da, wr_w, rw);
      e_drd = rw;
    end
    if (dw) begin
      s_wd = wd_post;
      access(1'b1, da, ww, GARB);
    end
    if (e_steps < 32'((1 << CW) - 1)) e_steps = e_steps + 32'd1;
    push(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, GARB);
    if (!act) e_halt = 1'b1;
  endtask

  task automatic gen_cpu_reset(input int n);
    s_cpurst = 1'b1;
    for (int i = 0; i < n; i++) begin
      push(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, GARB);
      e_halt = 1'b0; e_err = 1'b0; e_steps = '0;
    end
    s_cpurst = 1'b0;
    idle(1);
  endtask

  task automatic gen_reset(input int n);
    s_rst = 1'b0;
    e_ird = '0; e_drd = '0; e_steps = '0; e_halt = 1'b0; e_err = 1'b0;
    idle(n);
    s_rst = 1'b1;
    idle(1);
  endtask

  task automatic run_queue();
    cyc_t r;
    int k;
    k = 0; lat_first = -1; lat_en = -1; n_en = 0; n_bus = 0;
    while (q.size() > 0) begin
      r = q.pop_front();
      @(negedge clk);
      reset = r.rst_n; cpu_reset = r.cpurst; cpu_active = r.act;
      instr_address = r.ia; data_address = r.da; data_read = r.dr; data_write = r.dw;
      data_writedata = r.wd;
      bus.mem_waitrequest = r.waitr; bus.mem_readdata = r.rdata;
      #1;
      chk("mem_read",       32'(bus.mem_read),       32'(r.rd));
      chk("mem_write",      32'(bus.mem_write),      32'(r.wr));
      chk("mem_address",    bus.mem_address,         r.addr);
      chk("mem_writedata",  bus.mem_writedata,       r.wdo);
      chk("mem_byteenable", 32'(bus.mem_byteenable), r.wr ? 32'hF : 32'h0);
      chk("cpu_clk_enable", 32'(cpu_clk_enable),     32'(r.clken));
      chk("instr_readdata", instr_readdata,          r.ird);
      chk("data_readdata",  data_readdata,           r.drd);
      chk("step_count",     32'(step_count),         r.steps);
      chk("halted",         32'(halted),             32'(r.halted));
      chk("bus_error",      32'(bus_error),          32'(r.err));
      if (bus.mem_read === 1'b1 && lat_first < 0) lat_first = k;
      if (bus.mem_read === 1'b1 || bus.mem_write === 1'b1) n_bus++;
      if (cpu_clk_enable === 1'b1) begin
        n_en++;
        if (lat_en < 0) lat_en = k;
      end
      k++;
      cyc++;
    end
  endtask

  initial begin
    bus.mem_waitrequest = 1'b0;
    bus.mem_readdata = GARB;

    gen_reset(3);
    run_queue();

    // addiu, zero wait
    gen_step(32'hBFC0_0000, 32'h2408_0001, 32'h0, 1'b0, 1'b0, 1'b1, GARB, 32'h0, 32'h0, 0, 0, 0);
    run_queue();
    chk("t1_latency", 32'(lat_en - lat_first + 1), 32'd3);
    chk("t1_enables", 32'(n_en), 32'd1);
    chk("t1_steps", 32'(step_count), 32'd1);
    chk("t1_instr", instr_readdata, 32'h2408_0001);

    // lw with two wait cycles on the data read
    gen_step(32'hBFC0_0004, 32'h8C09_2000, 32'h0000_2000, 1'b1, 1'b0, 1'b1, 32'hCAFE_F00D,
             32'h0, 32'h0, 0, 2, 0);
    run_queue();
    chk("t2_latency", 32'(lat_en - lat_first + 1), 32'd6);
    chk("t2_load", data_readdata, 32'hCAFE_F00D);

    // sb to 0x1003: read-modify-write of word 0x1000
    gen_step(32'hBFC0_0008, 32'hA00A_1003, 32'h0000_1003, 1'b1, 1'b1, 1'b1, 32'h1122_3344,
             32'h0000_00AB, 32'hAB22_3344, 0, 0, 0);
    run_queue();
    chk("t3_latency", 32'(lat_en - lat_first + 1), 32'd5);
    chk("t3_enables", 32'(n_en), 32'd1);
    chk("t3_rmw_read", data_readdata, 32'h1122_3344);

    // sw with a waited fetch and write; step counter saturates
    gen_step(32'hBFC0_000C, 32'hAC0B_3000, 32'h0000_3000, 1'b0, 1'b1, 1'b1, GARB,
             32'h5555_AAAA, 32'h5555_AAAA, 1, 0, 1);
    run_queue();
    chk("t4_latency", 32'(lat_en - lat_first + 1), 32'd6);
    chk("t4_saturate", 32'(step_count), 32'd3);

    // core goes inactive: halt with a quiet bus
    gen_step(32'hBFC0_0010, 32'h0000_000D, 32'h0, 1'b0, 1'b0, 1'b0, GARB, 32'h0, 32'h0, 0, 0, 0);
    run_queue();
    idle(20);
    run_queue();
    chk("t5_quiet_bus", 32'(n_bus), 32'd0);
    chk("t5_no_enable", 32'(n_en), 32'd0);
    chk("t5_halted", 32'(halted), 32'd1);

    // cpu_reset recovery, then stuck waitrequest in fetch
    gen_cpu_reset(2);
    gen_step(32'hBFC0_0000, 32'h2408_0001, 32'h0, 1'b0, 1'b0, 1'b1, GARB, 32'h0, 32'h0, 0, 0, 0);
    run_queue();
    s_ia = 32'hBFC0_0004; s_dr = 1'b0; s_dw = 1'b0;
    for (int i = 0; i < int'(WL); i++) push(1'b1, 1'b0, 1'b0, 1'b1, s_ia, GARB);
    e_err = 1'b1; e_halt = 1'b1;
    idle(6);
    run_queue();
    chk("t6_strobe_cycles", 32'(n_bus), 32'(WL));
    chk("t6_no_enable", 32'(n_en), 32'd0);
    chk("t6_bus_error", 32'(bus_error), 32'd1);

    // async reset in the middle of a stalled data read
    gen_cpu_reset(1);
    s_ia = 32'hBFC0_0020; s_da = 32'h0000_4000; s_dr = 1'b1; s_dw = 1'b0; s_act = 1'b1;
    access(1'b0, s_ia, 0, 32'h8C0C_4000);
    e_ird = 32'h8C0C_4000;
    idle(1);
    for (int i = 0; i < 2; i++) push(1'b1, 1'b0, 1'b0, 1'b1, s_da, GARB);
    gen_reset(2);
    gen_step(32'hBFC0_0020, 32'h8C0C_4000, 32'h0000_4000, 1'b1, 1'b0, 1'b1, 32'h0BAD_F00D,
             32'h0, 32'h0, 0, 0, 0);
    run_queue();
    chk("t7_reload", data_readdata, 32'h0BAD_F00D);
    chk("t7_steps", 32'(step_count), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
